mac_seq_ctrl: RTL and testbench

//  Job sequencer for one mac_block_2 instance. Accepts a command (mode, acc/mult-only, init, length), streams
//  LEN operand beats into the MAC with en, drains the MAC output pipeline and returns one result word.

---
 rtl/mac_seq_ctrl_pkg.sv | 25 ++
 rtl/mac_seq_ctrl_lane_mux.sv | 50 +++++
 rtl/mac_seq_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_ctrl_pkg.sv
// mac_seq_ctrl_pkg
//   Shared definitions for the MAC job sequencer: MAC mode encodings,
//   sequencer state encoding and a small mode-legality helper.
//   Imported by mac_seq_ctrl and mac_seq_ctrl_lane_mux.
package mac_seq_ctrl_pkg;

  // MAC lane modes; 2'b11 is reserved and rejected at command time
  localparam logic [1:0] MAC_SINGLE       = 2'd0;
  localparam logic [1:0] MAC_DUAL         = 2'd1;
  localparam logic [1:0] MAC_QUAD         = 2'd2;
  localparam logic [1:0] MAC_MODE_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  function automatic logic isLegalMode(input logic [1:0] mode);
    return mode != MAC_MODE_ILLEGAL;
  endfunction

endpackage

// File: rtl/mac_seq_ctrl_lane_mux.sv
// mac_seq_ctrl_lane_mux
//   Combinational steering of a packed 4-lane operand word onto the MAC
//   A0..A3 inputs according to the MAC mode. All lanes are forced to zero
//   when i_en is low so the MAC sees clean zeros on bubble cycles.
// Ports
//   i_en        steer enable (operand beat firing this cycle)
//   i_mode      MAC mode (SINGLE/DUAL/QUAD)
//   i_a         packed A lanes, byte k -> lane k
//   o_a0..o_a3  MAC A0..A3 inputs
module mac_seq_ctrl_lane_mux #(
  parameter int MIN_W = 8
) (
  input  logic               i_en,
  input  logic [1:0]         i_mode,
  input  logic [4*MIN_W-1:0] i_a,
  output logic [MIN_W-1:0]   o_a0,
  output logic [MIN_W-1:0]   o_a1,
  output logic [MIN_W-1:0]   o_a2,
  output logic [MIN_W-1:0]   o_a3
);
  import mac_seq_ctrl_pkg::*;

  // SINGLE and DUAL use the upper MAC lanes (A2/A3) because that is where
  // the MAC's narrow-mode multipliers sit; unused lanes stay zero.
  always_comb begin
    o_a0 = '0;
    o_a1 = '0;
    o_a2 = '0;
    o_a3 = '0;
    if (i_en) begin
      case (i_mode)
        MAC_SINGLE: begin
          o_a2 = i_a[MIN_W-1:0];
        end
        MAC_DUAL: begin
          o_a2 = i_a[MIN_W-1:0];
          o_a3 = i_a[2*MIN_W-1:MIN_W];
        end
        MAC_QUAD: begin
          o_a0 = i_a[MIN_W-1:0];
          o_a1 = i_a[2*MIN_W-1:MIN_W];
          o_a2 = i_a[3*MIN_W-1:2*MIN_W];
          o_a3 = i_a[4*MIN_W-1:3*MIN_W];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl
//   Job sequencer for one MAC datapath. Accepts a command, resets/configures
//   the MAC, streams LEN operand beats with mac_en, waits MAC_LAT cycles for
//   the MAC pipeline and returns a single result word. One job at a time.
// Configuration
//   MAC_SEQ_PERF_EN : adds o_perf_jobs, a wrapping count of completed result
//                     handshakes (error jobs included), cleared by reset.
// Ports
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_cmd_*/o_cmd_ready        command: mode, acc/mult-only, init, length
//   i_op_*/o_op_ready          operand stream: packed A lanes and B
//   o_mac_*                    MAC controls: rst, en, cfg, A0..A3, B2
//   i_mac_c                    MAC result
//   o_res_*/i_res_ready        result: valid held until ready, data, error
//   o_busy                     sequencer not idle
module mac_seq_ctrl #(
  parameter int MIN_W   = 8,
  parameter int ACC_W   = 32,
  parameter int CONF_W  = 3,
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic [1:0]              i_cmd_mode,
  input  logic                    i_cmd_acc,
  input  logic [ACC_W-1:0]        i_cmd_init,
  input  logic [LEN_W-1:0]        i_cmd_len,
  input  logic                    i_op_valid,
  output logic                    o_op_ready,
  input  logic [4*MIN_W-1:0]      i_op_a,
  input  logic [MIN_W-1:0]        i_op_b,
  output logic                    o_mac_rst,
  output logic                    o_mac_en,
  output logic [ACC_W+CONF_W-1:0] o_mac_cfg,
  output logic [MIN_W-1:0]        o_mac_a0,
  output logic [MIN_W-1:0]        o_mac_a1,
  output logic [MIN_W-1:0]        o_mac_a2,
  output logic [MIN_W-1:0]        o_mac_a3,
  output logic [MIN_W-1:0]        o_mac_b2,
  input  logic [ACC_W-1:0]        i_mac_c,
  output logic                    o_res_valid,
  input  logic                    i_res_ready,
  output logic [ACC_W-1:0]        o_res_data,
  output logic                    o_res_err,
  output logic                    o_busy
`ifdef MAC_SEQ_PERF_EN
  ,
  output logic [31:0]             o_perf_jobs
`endif
);
  import mac_seq_ctrl_pkg::*;

  localparam int DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT + 1) : 1;

  seq_state_t               r_state;
  seq_state_t               w_next_state;
  logic [1:0]               r_mode;
  logic                     r_acc;
  logic [ACC_W-1:0]         r_init;
  logic [LEN_W-1:0]         r_beats;
  logic [DRAIN_W-1:0]       r_drain;
  logic [ACC_W-1:0]         r_res_data;
  logic                     r_res_err;
  logic                     w_lane_en;
  logic [ACC_W+CONF_W-1:0]  w_cfg;
  logic                     w_cmd_fire;
  logic                     w_op_fire;
  logic                     w_res_fire;

  assign w_cmd_fire = o_cmd_ready & i_cmd_valid;
  assign w_op_fire  = o_op_ready & i_op_valid;
  assign w_res_fire = o_res_valid & i_res_ready;
  assign o_res_data = r_res_data;
  assign o_res_err  = r_res_err;

  // MAC config word: {init, acc, zero padding, mode}
  always_comb begin
    w_cfg                          = '0;
    w_cfg[1:0]                     = r_mode;
    w_cfg[CONF_W-1]                = r_acc;
    w_cfg[ACC_W+CONF_W-1:CONF_W]   = r_init;
  end

  // Next state and outputs. Everything except mac_rst is held low while
  // reset is asserted so the fabric never sees a handshake from a job that
  // is being discarded.
  always_comb begin
    w_next_state = r_state;
    o_cmd_ready  = 1'b0;
    o_op_ready   = 1'b0;
    o_mac_en     = 1'b0;
    o_mac_rst    = i_rst;
    o_mac_cfg    = '0;
    o_mac_b2     = '0;
    o_res_valid  = 1'b0;
    o_busy       = 1'b0;
    w_lane_en    = 1'b0;
    if (!i_rst) begin
      o_busy = (r_state != ST_IDLE);
      if (r_state != ST_IDLE) o_mac_cfg = w_cfg;
      case (r_state)
        ST_IDLE: begin
          o_cmd_ready = 1'b1;
          if (i_cmd_valid) begin
            // Illegal modes and empty jobs never touch the MAC
            if (!isLegalMode(i_cmd_mode) || (i_cmd_len == '0))
              w_next_state = ST_DONE;
            else
              w_next_state = ST_LOAD;
          end
        end
        ST_LOAD: begin
          o_mac_rst    = 1'b1;
          w_next_state = ST_RUN;
        end
        ST_RUN: begin
          o_op_ready = 1'b1;
          if (i_op_valid) begin
            o_mac_en  = 1'b1;
            w_lane_en = 1'b1;
            o_mac_b2  = i_op_b;
            if (r_beats == LEN_W'(1)) w_next_state = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_drain == DRAIN_W'(1)) w_next_state = ST_DONE;
        end
        ST_DONE: begin
          o_res_valid = 1'b1;
          if (i_res_ready) w_next_state = ST_IDLE;
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // State, latched command fields and counters. res_data is preloaded at
  // command time so the error and zero-length jobs are already complete
  // when they land in DONE; real jobs overwrite it on the last DRAIN cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_mode     <= '0;
      r_acc      <= 1'b0;
      r_init     <= '0;
      r_beats    <= '0;
      r_drain    <= '0;
      r_res_data <= '0;
      r_res_err  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_cmd_fire) begin
        r_mode     <= i_cmd_mode;
        r_acc      <= i_cmd_acc;
        r_init     <= i_cmd_init;
        r_beats    <= i_cmd_len;
        r_res_err  <= !isLegalMode(i_cmd_mode);
        r_res_data <= (isLegalMode(i_cmd_mode) && i_cmd_acc && (i_cmd_len == '0))
                      ? i_cmd_init : '0;
      end
      if (w_op_fire) begin
        r_beats <= r_beats - LEN_W'(1);
        if (r_beats == LEN_W'(1)) r_drain <= DRAIN_W'(MAC_LAT);
      end
      if (r_state == ST_DRAIN) begin
        r_drain <= r_drain - DRAIN_W'(1);
        if (r_drain == DRAIN_W'(1)) r_res_data <= i_mac_c;
      end
    end
  end

`ifdef MAC_SEQ_PERF_EN
  logic [31:0] r_perf_jobs;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_perf_jobs <= '0;
    else if (w_res_fire)
      r_perf_jobs <= r_perf_jobs + 32'd1;
  end

  assign o_perf_jobs = r_perf_jobs;
`else
  logic w_unused_res_fire;
  assign w_unused_res_fire = w_res_fire;
`endif

  mac_seq_ctrl_lane_mux #(
    .MIN_W (MIN_W)
  ) u_lane_mux (
    .i_en   (w_lane_en),
    .i_mode (r_mode),
    .i_a    (i_op_a),
    .o_a0   (o_mac_a0),
    .o_a1   (o_mac_a1),
    .o_a2   (o_mac_a2),
    .o_a3   (o_mac_a3)
  );

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl
//   Bench for mac_seq_ctrl: a behavioural MAC stub answers the DUT's MAC
//   port, and each job's expected result, error flag and latency come from
//   a job-level reference model over the beats the bench sends.
module tb_mac_seq_ctrl;

  localparam int MIN_W   = 8;
  localparam int ACC_W   = 32;
  localparam int CONF_W  = 3;
  localparam int LEN_W   = 8;
  localparam int MAC_LAT = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmdValid, cmdReady, cmdAcc;
  logic [1:0]  cmdMode;
  logic [31:0] cmdInit;
  logic [7:0]  cmdLen;
  logic        opValid, opReady;
  logic [31:0] opA;
  logic [7:0]  opB;
  logic        macRst, macEn;
  logic [34:0] macCfg;
  logic [7:0]  macA0, macA1, macA2, macA3, macB2;
  logic [31:0] macC;
  logic        resValid, resReady, resErr, busy;
  logic [31:0] resData;
`ifdef MAC_SEQ_PERF_EN
  logic [31:0] perfJobs;
`endif

  int testsRun    = 0;
  int testsFailed = 0;
  int jobsDone    = 0;

  logic [31:0] beatA [256];
  logic [7:0]  beatB [256];

  always #5 clock = ~clock;

  mac_seq_ctrl #(
    .MIN_W(MIN_W), .ACC_W(ACC_W), .CONF_W(CONF_W), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT)
  ) dut (
    .i_clk(clock), .i_rst(reset),
    .i_cmd_valid(cmdValid), .o_cmd_ready(cmdReady), .i_cmd_mode(cmdMode),
    .i_cmd_acc(cmdAcc), .i_cmd_init(cmdInit), .i_cmd_len(cmdLen),
    .i_op_valid(opValid), .o_op_ready(opReady), .i_op_a(opA), .i_op_b(opB),
    .o_mac_rst(macRst), .o_mac_en(macEn), .o_mac_cfg(macCfg),
    .o_mac_a0(macA0), .o_mac_a1(macA1), .o_mac_a2(macA2), .o_mac_a3(macA3),
    .o_mac_b2(macB2), .i_mac_c(macC),
    .o_res_valid(resValid), .i_res_ready(resReady), .o_res_data(resData),
    .o_res_err(resErr), .o_busy(busy)
`ifdef MAC_SEQ_PERF_EN
    , .o_perf_jobs(perfJobs)
`endif
  );

  // MAC stub: loads init on mac_rst, adds or replaces the per-beat product
  // on mac_en; result visible one cycle after the enable beat.
  logic [31:0] stubAcc;
  logic [31:0] stubProd;
  assign macC = stubAcc;

  always_comb begin
    stubProd = '0;
    case (macCfg[1:0])
      2'd0: stubProd = 32'(macA2) * 32'(macB2);
      2'd1: stubProd = {16'(macA3) * 16'(macB2), 16'(macA2) * 16'(macB2)};
      2'd2: stubProd = {8'(macA3 * macB2), 8'(macA2 * macB2),
                        8'(macA1 * macB2), 8'(macA0 * macB2)};
      default: stubProd = '0;
    endcase
  end

  always @(posedge clock) begin
    if (macRst)
      stubAcc <= macCfg[34:3];
    else if (macEn)
      stubAcc <= macCfg[2] ? stubAcc + stubProd : stubProd;
  end

  // Product of one beat as the job semantics define it, from raw operand bytes
  function automatic logic [31:0] beatProduct(input logic [1:0] mode, input logic [31:0] a,
                                              input logic [7:0] b);
    case (mode)
      2'd0: return 32'(a[7:0]) * 32'(b);
      2'd1: return {16'(a[15:8]) * 16'(b), 16'(a[7:0]) * 16'(b)};
      2'd2: return {8'(a[31:24] * b), 8'(a[23:16] * b), 8'(a[15:8] * b), 8'(a[7:0] * b)};
      default: return 32'd0;
    endcase
  endfunction

  // Expected {A0,A1,A2,A3} for a firing beat
  function automatic logic [31:0] expectedLanes(input logic [1:0] mode, input logic [31:0] a);
    case (mode)
      2'd0: return {8'h00, 8'h00, a[7:0], 8'h00};
      2'd1: return {8'h00, 8'h00, a[7:0], a[15:8]};
      2'd2: return {a[7:0], a[15:8], a[23:16], a[31:24]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkPerf();
`ifdef MAC_SEQ_PERF_EN
    checkOutput("perf_jobs", 64'(perfJobs), 64'(jobsDone));
`endif
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1; cmdValid = 1'b0; opValid = 1'b0; resReady = 1'b0;
    #1;
    checkOutput("rst_mac_rst", 64'(macRst), 64'd1);
    checkOutput("rst_cmd_ready", 64'(cmdReady), 64'd0);
    checkOutput("rst_op_ready", 64'(opReady), 64'd0);
    checkOutput("rst_res_valid", 64'(resValid), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    jobsDone = 0;
    #1;
    checkOutput("post_rst_cmd_ready", 64'(cmdReady), 64'd1);
    checkOutput("post_rst_busy", 64'(busy), 64'd0);
    checkOutput("post_rst_mac_rst", 64'(macRst), 64'd0);
    checkOutput("post_rst_res_data", 64'(resData), 64'd0);
    checkPerf();
  endtask

  // One complete job: command, beats (with optional bubbles), result, handshake
  task automatic applyStimulus(input logic [1:0] mode, input logic acc, input logic [31:0] init,
                               input int len, input logic [255:0] bubbleMask, input int holdCycles);
    logic [31:0] expData, sum, lastProd;
    logic        expErr;
    int          expLat, nBubbles, lat, waitCnt;
    time         fireTime;

    expErr = (mode == 2'd3);
    sum = init; lastProd = '0; nBubbles = 0;
    for (int i = 0; i < len; i++) begin
      lastProd = beatProduct(mode, beatA[i], beatB[i]);
      sum      = sum + lastProd;
      if (bubbleMask[i]) nBubbles++;
    end
    if (expErr)        expData = '0;
    else if (len == 0) expData = acc ? init : '0;
    else               expData = acc ? sum : lastProd;
    expLat = (expErr || len == 0) ? 0 : len + nBubbles + MAC_LAT + 1;

    @(negedge clock);
    cmdValid = 1'b1; cmdMode = mode; cmdAcc = acc; cmdInit = init; cmdLen = 8'(len);
    #1;
    checkOutput("cmd_ready_idle", 64'(cmdReady), 64'd1);
    @(posedge clock);
    fireTime = $time;
    @(negedge clock);
    cmdValid = 1'b0;
    if (!expErr && len > 0) begin
      #1;
      checkOutput("load_mac_rst", 64'(macRst), 64'd1);
      checkOutput("load_cfg", 64'(macCfg), 64'({init, acc, mode}));
      checkOutput("load_op_ready", 64'(opReady), 64'd0);
      @(negedge clock);
      for (int i = 0; i < len; i++) begin
        if (bubbleMask[i]) begin
          opValid = 1'b0;
          #1;
          checkOutput("bubble_op_ready", 64'(opReady), 64'd1);
          checkOutput("bubble_quiet", 64'({macEn, macA0, macA1, macA2, macA3, macB2}), 64'd0);
          @(negedge clock);
        end
        opValid = 1'b1; opA = beatA[i]; opB = beatB[i];
        #1;
        waitCnt = 0;
        while (!opReady && waitCnt < 8) begin
          @(negedge clock); #1; waitCnt++;
        end
        checkOutput("beat_en", 64'(macEn), 64'd1);
        checkOutput("beat_lanes", 64'({macA0, macA1, macA2, macA3}),
                    64'(expectedLanes(mode, beatA[i])));
        checkOutput("beat_b2", 64'(macB2), 64'(beatB[i]));
        @(negedge clock);
      end
      opValid = 1'b0; opA = '0; opB = '0;
    end

    for (int k = 0; k < 40 && !resValid; k++) @(negedge clock);
    checkOutput("res_valid_seen", 64'(resValid), 64'd1);
    if (!resValid) begin
      doReset();
      return;
    end
    lat = int'(($time - fireTime - 5) / 10);
    checkOutput("latency", 64'(lat), 64'(expLat));
    checkOutput("res_data", 64'(resData), 64'(expData));
    checkOutput("res_err", 64'(resErr), 64'(expErr));

    for (int h = 0; h < holdCycles; h++) begin
      #1;
      checkOutput("hold_valid", 64'(resValid), 64'd1);
      checkOutput("hold_data", 64'(resData), 64'(expData));
      checkOutput("hold_cmd_op_ready", 64'({cmdReady, opReady}), 64'd0);
      @(negedge clock);
    end
    resReady = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resReady = 1'b0;
    jobsDone++;
    #1;
    checkOutput("after_hs_valid", 64'(resValid), 64'd0);
    checkOutput("after_hs_cmd_ready", 64'(cmdReady), 64'd1);
    checkOutput("after_hs_busy", 64'(busy), 64'd0);
    checkPerf();
  endtask

  // Start a 4-beat job, feed two beats, then reset in RUN
  task automatic abortJob();
    @(negedge clock);
    cmdValid = 1'b1; cmdMode = 2'd2; cmdAcc = 1'b1; cmdInit = 32'h77; cmdLen = 8'd4;
    @(negedge clock);
    cmdValid = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      opValid = 1'b1; opA = $urandom; opB = 8'($urandom);
      @(negedge clock);
    end
    opValid = 1'b0;
    #1;
    checkOutput("abort_in_run", 64'(busy), 64'd1);
    doReset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); #1;
      checkOutput("abort_no_result", 64'(resValid), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0]   mode;
    logic [255:0] mask;
    int           len, r;

    reset = 1'b1; cmdValid = 1'b0; cmdMode = '0; cmdAcc = 1'b0; cmdInit = '0; cmdLen = '0;
    opValid = 1'b0; opA = '0; opB = '0; resReady = 1'b0;
    @(negedge clock);
    #1;
    checkOutput("reset_mac_rst", 64'(macRst), 64'd1);
    checkOutput("reset_cmd_ready", 64'(cmdReady), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("reset_idle", 64'({cmdReady, busy, resValid, resErr, opReady, macEn, macRst}),
                64'b1000000);
    checkOutput("reset_data_cfg", 64'({resData, macCfg[31:0]}), 64'd0);

    // QUAD accumulate, two identical beats
    beatA[0] = 32'h01010101; beatB[0] = 8'd2;
    beatA[1] = 32'h01010101; beatB[1] = 8'd2;
    applyStimulus(2'd2, 1'b1, 32'd5, 2, '0, 0);

    // SINGLE accumulate with a bubble before the second beat
    beatA[0] = 32'd1; beatB[0] = 8'd3;
    beatA[1] = 32'd2; beatB[1] = 8'd3;
    beatA[2] = 32'd3; beatB[2] = 8'd3;
    mask = '0; mask[1] = 1'b1;
    applyStimulus(2'd0, 1'b1, 32'd10, 3, mask, 0);

    // DUAL multiply-only: only the last beat's product survives
    beatA[0] = 32'h0203; beatB[0] = 8'd4;
    beatA[1] = 32'h0105; beatB[1] = 8'd2;
    applyStimulus(2'd1, 1'b0, 32'h9999, 2, '0, 1);

    // Zero-length jobs and the illegal mode
    applyStimulus(2'd0, 1'b1, 32'h1234, 0, '0, 0);
    applyStimulus(2'd1, 1'b0, 32'h1234, 0, '0, 1);
    applyStimulus(2'd3, 1'b1, 32'hABCD, 5, '0, 3);

    // Consumer stalls for five cycles
    beatA[0] = 32'h11223344; beatB[0] = 8'd7;
    applyStimulus(2'd2, 1'b1, 32'h100, 1, '0, 5);

    // Reset in the middle of RUN, then a normal job
    abortJob();
    beatA[0] = 32'h0000FF10; beatB[0] = 8'hFF;
    beatA[1] = 32'h00008001; beatB[1] = 8'h80;
    beatA[2] = 32'h00000203; beatB[2] = 8'h11;
    applyStimulus(2'd1, 1'b1, 32'd100, 3, '0, 0);

    // Longest job the length field allows
    for (int i = 0; i < 255; i++) begin
      beatA[i] = $urandom; beatB[i] = 8'($urandom);
    end
    applyStimulus(2'd2, 1'b1, $urandom, 255, '0, 0);

    // Randomized jobs
    for (int j = 0; j < 30; j++) begin
      r    = int'($urandom_range(0, 7));
      mode = (r == 7) ? 2'd3 : 2'(r % 3);
      len  = int'($urandom_range(0, 9));
      mask = '0;
      for (int i = 0; i < len; i++) begin
        beatA[i] = $urandom;
        beatB[i] = 8'($urandom);
        mask[i]  = ($urandom_range(0, 3) == 0);
      end
      applyStimulus(mode, 1'($urandom_range(0, 1)), $urandom, len, mask,
                    int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
